// File: rtl/serial_sub_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// serial_sub_ctrl: bit-serial subtractor computing {bout,d} = a - b - bin,
// one bit per clock LSB first, through a single 1-bit full subtractor.

module full_sub (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ c;
  assign bo = (~a & (b | c)) | (b & c);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fs_d;
  logic             fs_bo;

  full_sub u_fs (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .c  (brw_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    d_d     = d_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        res_d  = WIDTH'({fs_d, res_q} >> 1);
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        brw_d  = fs_bo;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          d_d     = res_d;
          bout_d  = fs_bo;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      d_q     <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      d_q     <= d_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bout = bout_q;

endmodule
`default_nettype wire
